input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of independent input lanes.
REQ-002 SHALL provide parameter STABLE_CYCLES, default 16, legal range 2..65535: consecutive equal samples needed to commit a new level.
REQ-003 SHALL provide port clk  input  1: single clock; all state is on its rising edge.
REQ-004 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL provide port in  input  WIDTH: raw asynchronous inputs (switches, buttons) feeding downstream gate logic.
REQ-006 SHALL provide port out  output  WIDTH: debounced, clk-synchronous level per lane.
REQ-007 SHALL provide port rise  output  WIDTH: one-cycle pulse per lane when out goes 0->1.
REQ-008 SHALL provide port fall  output  WIDTH: one-cycle pulse per lane when out goes 1->0.

Function
REQ-009 Each lane SHALL pass in[i] through a two-flop synchronizer; s[i] denotes the second flop's output.
REQ-010 Each lane SHALL run a 4-state FSM: STABLE_LO (out=0), WAIT_HI (out=0), STABLE_HI (out=1), WAIT_LO (out=1).
REQ-011 In STABLE_LO, s=1 SHALL move the lane to WAIT_HI with cnt=1; s=0 SHALL hold the state.
REQ-012 In WAIT_HI, s=0 SHALL return the lane to STABLE_LO with cnt=0.
REQ-013 In WAIT_HI, s=1 with cnt<STABLE_CYCLES-1 SHALL increment cnt.
REQ-014 In WAIT_HI, s=1 with cnt==STABLE_CYCLES-1 SHALL move to STABLE_HI, set out=1 and clear cnt.
REQ-015 STABLE_HI and WAIT_LO SHALL mirror REQ-011..014 with polarities swapped.
REQ-016 Latency: with in[i] newly high and first captured at edge 0, out[i] SHALL rise at edge STABLE_CYCLES+1, provided in[i] stays high throughout.
REQ-017 Any sample disagreeing with the pending level during WAIT_* SHALL discard the partial count; there SHALL be no partial credit or hysteresis beyond this.
REQ-018 cnt SHALL be $clog2(STABLE_CYCLES) bits wide, SHALL never wrap, and SHALL never exceed STABLE_CYCLES-1.
REQ-019 out SHALL be driven directly from a register, with no combinational path from in.
REQ-020 rise[i]/fall[i] SHALL be registered, asserted in the same cycle out[i] changes, and high for exactly one cycle.
REQ-021 Lanes SHALL be fully independent; simultaneous transitions on several lanes SHALL each meet REQ-016.

Reset
REQ-022 rst_n low SHALL asynchronously force sync flops=0, all lanes to STABLE_LO, cnt=0, out=0, rise=0, fall=0.
REQ-023 Reset asserted mid-WAIT_* SHALL abandon the pending transition; after release, timing SHALL restart from REQ-011.
REQ-024 Deassertion of rst_n SHALL take effect on the first clk edge after release; an in already high SHALL then qualify per REQ-016 and produce a rise pulse.

Configuration
REQ-025 Macro INPUT_DEBOUNCER_EDGE_PULSE_EN SHALL compile in the rise/fall pulse logic.
REQ-026 With the macro undefined, rise and fall ports SHALL remain present and be tied to 0, and the out behaviour SHALL be identical.

Structure
REQ-027 A shared package input_debouncer_pkg SHALL hold the 2-bit state encodings (STABLE_LO=00, WAIT_HI=01, STABLE_HI=11, WAIT_LO=10) and the default STABLE_CYCLES constant.
REQ-028 The per-lane synchronizer, FSM and counter SHALL live in sub-module debounce_lane, instantiated WIDTH times by a generate loop.

Verification (WIDTH=2, STABLE_CYCLES=4)
REQ-029 Reset: in=11 with rst_n=0 -> out=00, rise=00, fall=00 immediately without a clock edge; after release, out=11 at edge 5 with rise=11 for one cycle.
REQ-030 Clean step: in[0] 0->1 captured at edge 0 and held -> out[0]=1 after edge 5; rise[0]=1 only in the cycle following edge 5; out[1] unchanged.
REQ-031 Glitch: in[0] high for 3 cycles then low -> out[0] stays 0, rise[0] never asserts.
REQ-032 Bounce: in[0] samples 1,0,1,1,1,1 -> out[0] rises 4 edges after the second rising sample, not the first.
REQ-033 Reset mid-wait: rst_n pulsed low while lane 0 is in WAIT_LO with cnt=3 -> out[0]=0 immediately and no fall pulse is emitted.
REQ-034 Macro off: the same REQ-030 stimulus -> identical out waveform, with rise=fall=00 at all times.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: per-lane FSM state encodings
// and the default stability window length.
package input_debouncer_pkg;

  // Bit 1 of the encoding is the committed output level of the lane.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } lane_state_e;

  localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/input_debouncer_lane.sv
// One debouncer lane: two-flop synchronizer, 4-state qualification FSM and
// run-length counter. Edge pulses exist only with INPUT_DEBOUNCER_EDGE_PULSE_EN.
module debounce_lane
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q, sync_d;
  lane_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], in};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The committed level is the state register's upper bit, so out is a flop.
  assign out = state_q[1];

`ifdef INPUT_DEBOUNCER_EDGE_PULSE_EN
  logic rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    rise_d = (state_q == WAIT_HI) && (state_d == STABLE_HI);
    fall_d = (state_q == WAIT_LO) && (state_d == STABLE_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Multi-lane switch/button debouncer; WIDTH independent debounce_lane instances.
// Define INPUT_DEBOUNCER_EDGE_PULSE_EN to get rise/fall pulses (else tied to 0).
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
